// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and
// the baud-divider computation used at elaboration.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per line bit, truncated; clk_freq_mhz is in MHz.
  function automatic int clks_per_bit(input int clk_freq_mhz, input int baud);
    return (clk_freq_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART shifter. Pushes while full are ignored,
// even when a pop happens on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop
// shifter paced by a baud counter. The line output is registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_t     state;
  tx_state_t     state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tx_q;
  logic          bit_end;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_data;
  logic          fifo_full;
  logic          fifo_empty;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered FIFO state and rst, never on in_valid.
  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  assign bit_end  = (baud_cnt == LAST_TICK);
  assign busy     = (state != IDLE) || !fifo_empty;
  assign tx       = tx_q;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) state_next = STOP;
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx follows the state one cycle late, so every frame is exactly
  // 10 bit periods on the line and the stop bit is never cut short.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state <= state_next;
      if (pop)                        shift <= fifo_data;
      else if (state == DATA && bit_end) shift <= {1'b0, shift[7:1]};
      if (pop)                        bit_cnt <= '0;
      else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
      if (state == IDLE || bit_end)   baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      case (state)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift[0];
        default: tx_q <= 1'b1;
      endcase
    end
  end

endmodule
